serial_add_sub_ctrl: RTL

Bit-serial add/subtract controller that sequences one 1-bit full-adder cell (sum/carry) over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start request, runs the carry chain through an internal carry flip-flop, and returns a WIDTH-bit result with carry and signed-overflow flags and a one-cycle done pulse. It is the sequencer that lets the adder/subtractor datapath do multi-bit arithmetic with a single full-adder cell instead of a ripple chain.

---
 rtl/serial_add_sub_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/sub sequencer: one full-adder cell, LSB first, WIDTH edges from accept to done.
// No backpressure: start is accepted only in IDLE/DONE and is ignored while busy; nothing is queued.
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_cy;
    logic             r_c;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_cout;

    assign w_accept = (r_state != ST_RUN) && start;
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_bit    = r_a_sh[0] ^ r_b_sh[0] ^ r_cy;
    assign w_cout   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_cy) | (r_b_sh[0] & r_cy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction loads ~b with carry-in 1, so the cell always adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_cy   <= 1'b0;
            r_s    <= '0;
            r_c    <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= sub ? ~b : b;
            r_cy   <= sub;
            r_cnt  <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= {w_bit, r_res[WIDTH-1:1]};
            r_cy   <= w_cout;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_s   <= {w_bit, r_res[WIDTH-1:1]};
                r_c   <= w_cout;
                r_ovf <= r_cy ^ w_cout;
            end
        end
    end

    assign s   = r_s;
    assign c   = r_c;
    assign ovf = r_ovf;

endmodule
